// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: pipeline vs multi-cycle writeback, with
// starvation guard and a pending-destination scoreboard for RAW stalls.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            p_valid,
  output logic            p_ready,
  input  logic [4:0]      p_rd,
  input  logic [XLEN-1:0] p_data,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [4:0]      m_rd,
  input  logic [XLEN-1:0] m_data,
  input  logic            m_issue,
  input  logic [4:0]      m_issue_rd,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            q_busy1,
  output logic            q_busy2,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            sb_err
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            rf_src_m_q, rf_src_m_d;
  logic [31:0]     pend_q, pend_d;
  logic            sb_err_q, sb_err_d;

  logic grant_m;
  logic p_acc;
  logic m_acc;
  logic clr_en;
  logic set_en;
  logic clr_hit;

  assign grant_m = m_valid && (!p_valid || (starve_cnt_q == STARVE_MAX));
  assign m_ready = grant_m;
  assign p_ready = !grant_m;
  assign m_acc   = grant_m;
  assign p_acc   = p_valid && !grant_m;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m_valid || m_acc) begin
      starve_cnt_d = 4'd0;
    end else if (p_valid && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Writes to x0 are consumed but never raise the write enable.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    rf_src_m_d = rf_src_m_q;
    if (m_acc) begin
      rf_we_d    = (m_rd != 5'd0);
      rf_rd_d    = m_rd;
      rf_wdata_d = m_data;
      rf_src_m_d = 1'b1;
    end else if (p_acc) begin
      rf_we_d    = (p_rd != 5'd0);
      rf_rd_d    = p_rd;
      rf_wdata_d = p_data;
      rf_src_m_d = 1'b0;
    end
  end

  assign clr_en  = rf_we_q && rf_src_m_q;
  assign set_en  = m_issue && (m_issue_rd != 5'd0);
  assign clr_hit = clr_en && (rf_rd_q == m_issue_rd);

  // Clear first so a same-index issue on the clearing edge wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) begin
      pend_d[rf_rd_q] = 1'b0;
    end
    if (set_en) begin
      pend_d[m_issue_rd] = 1'b1;
    end
  end

  always_comb begin
    sb_err_d = sb_err_q;
    if (set_en && pend_q[m_issue_rd] && !clr_hit) begin
      sb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= 4'd0;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= 5'd0;
      rf_wdata_q   <= '0;
      rf_src_m_q   <= 1'b0;
      pend_q       <= 32'd0;
      sb_err_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_src_m_q   <= rf_src_m_d;
      pend_q       <= pend_d;
      sb_err_q     <= sb_err_d;
    end
  end

  assign q_busy1  = pend_q[q_rs1];
  assign q_busy2  = pend_q[q_rs2];
  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign sb_err   = sb_err_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Arbitrates the register file's single write port between two writeback sources: the in-order pipeline writeback stage and the multi-cycle unit (mul/div, slow loads). It keeps a 32-entry pending scoreboard for destinations of in-flight multi-cycle operations, so decode can stall on RAW hazards. It sits between the writeback sources and the register file write port, and drives `rf_we`, `rf_rd` and `rf_wdata` from registers.

## Interface
- `XLEN`, 32, data width.
- `STARVE_LIMIT`, 4, number of consecutive lost arbitrations after which the multi-cycle unit is granted over the pipeline (1..15).
- `clk  in  1  clock`
- `reset_n  in  1  asynchronous, active-low reset`
- `p_valid  in  1  pipeline writeback request`
- `p_ready  out  1  pipeline request accepted this cycle`
- `p_rd  in  5  pipeline destination register`
- `p_data  in  XLEN  pipeline write data`
- `m_valid  in  1  multi-cycle unit writeback request`
- `m_ready  out  1  multi-cycle request accepted this cycle`
- `m_rd  in  5  multi-cycle destination register`
- `m_data  in  XLEN  multi-cycle write data`
- `m_issue  in  1  multi-cycle operation issued; marks `m_issue_rd` pending`
- `m_issue_rd  in  5  destination of the issued operation`
- `q_rs1, q_rs2  in  5 each  scoreboard query addresses`
- `q_busy1, q_busy2  out  1 each  queried register pending (combinational)`
- `rf_we  out  1  register file write enable`
- `rf_rd  out  5  register file write address`
- `rf_wdata  out  XLEN  register file write data`
- `sb_err  out  1  sticky: `m_issue` to an already-pending register`

## Operation
- Grant logic (combinational):
  - `grant_m = m_valid && (!p_valid || starve_cnt == STARVE_LIMIT)`.
  - `m_ready = grant_m`.
  - `p_ready = !grant_m`. The pipeline is ready whenever the multi-cycle unit is not granted, including when `p_valid` is low.
- Readies depend on valids. Requesters must hold valid and payload stable until accepted.
- A request is accepted on `valid && ready`.
- Starvation counter (4-bit):
  - Increments, saturating at STARVE_LIMIT, when `m_valid && p_valid && !grant_m`.
  - Clears when `m_valid` is low or when the multi-cycle unit is accepted.
- Write register: on an accept, `rf_we`, `rf_rd` and `rf_wdata` load the winner's signals on the next edge.
  - When the winner's rd is 0, the request is still accepted, but `rf_we` loads 0. Writes to x0 never reach the register file.
  - With no accept, `rf_we` loads 0. `rf_rd` and `rf_wdata` hold their values.
- Scoreboard `pend[31:0]`:
  - Set: `m_issue` with `m_issue_rd != 0` sets `pend[m_issue_rd]`. Issues to x0 are ignored.
  - Clear: `pend[rf_rd]` clears on the edge ending a cycle where `rf_we` is 1 and the write was a multi-cycle write. A 1-bit source tag is registered alongside `rf_we`. Pipeline writes never clear pend bits.
  - Set and clear of the same index on the same edge: set wins.
  - `m_issue` to an index already pending (and not clearing that edge) sets `sb_err`. `sb_err` clears only on reset.
- Query: `q_busyN = pend[q_rsN]`. x0 always reads 0 because `pend[0]` is never set.
- Reset: `rf_we=0`, `rf_rd=0`, `rf_wdata=0`, `pend=0`, `starve_cnt=0`, `sb_err=0`. `p_ready` and `m_ready` follow the combinational rule from the reset state (`p_ready=1` when `m_valid=0`).
- Reset asserted mid-operation drops any accepted but not yet written request. No write occurs while `reset_n` is low.

## Timing
- Accept at cycle N:
  - `rf_we`, `rf_rd` and `rf_wdata` are valid throughout cycle N+1.
  - The register file captures the data at the end of cycle N+1.
- Pending-bit clear for a multi-cycle accept at cycle N:
  - `q_busy` stays 1 through cycle N+1.
  - `q_busy` reads 0 from cycle N+2, the same cycle the register file read port returns the new value.
- `m_issue` at cycle N: `q_busy` is 1 from cycle N+1.
- Throughput: one write per cycle. Back-to-back accepts produce `rf_we` high on consecutive cycles.
- Worst-case multi-cycle wait under continuous pipeline traffic is STARVE_LIMIT cycles. The multi-cycle unit is accepted in cycle STARVE_LIMIT+1 after `m_valid` rises.

## Test plan
- Reset with both valids low:
  - `rf_we=0`, `p_ready=1`, `m_ready=0`, all `q_busy=0`, `sb_err=0`.
- Single pipeline write, `p_rd=5`, `p_data=0xDEADBEEF` at cycle N:
  - Cycle N+1 shows `rf_we=1`, `rf_rd=5`, `rf_wdata=0xDEADBEEF`.
  - Cycle N+2 shows `rf_we=0`.
- Starvation:
  - Stimulus: `p_valid` held 1 continuously, `m_valid=1` from cycle 0, `m_rd=7`, STARVE_LIMIT=4.
  - Cycles 0-3: `p_ready=1`.
  - Cycle 4: `m_ready=1`, `p_ready=0`.
  - Cycle 5: `rf_rd=7`; the counter has cleared.
- Scoreboard:
  - `m_issue` rd=9 at cycle 0: `q_busy1` (rs1=9) reads 1 from cycle 1.
  - Multi-cycle accept rd=9 at cycle 10: `q_busy1` reads 1 at cycle 11 and 0 at cycle 12.
- x0 and hazard edges:
  - Pipeline write with rd=0: accepted, `rf_we` stays 0.
  - `m_issue` rd=0: `pend` unchanged.
  - `m_issue` rd=3 twice with no intervening write: `sb_err=1`.
  - `m_issue` rd=3 on the clearing edge of rd=3: `q_busy` stays 1, `sb_err` stays 0.
- Reset mid-transfer:
  - Stimulus: pipeline accept at cycle N, then `reset_n` low during cycle N+1 before the edge.
  - `rf_we` drops to 0 immediately and all pend bits are 0.
  - After release, the first write requires a new accept.
